// File: rtl/noc_local_ni.sv
// Local network interface between a tile core and its router's L port.
// Latency: tx flit reaches net_data_o/net_enable_o 1 cycle after acceptance; rx flit is visible 1 cycle after the write.
// Backpressure: tx is gated by router credits (tx_ready_o); rx FIFO returns one credit per popped flit, drops on full.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   tx_valid_i/dest/payload  core tx request; tx_ready_o accepts it
//   net_data_o/enable_o      flit + write strobe to router input FIFO; net_credit_i returns a slot
//   net_data_i/enable_i      flit + write strobe from router; net_credit_o returns a slot
//   rx_data_o/valid_o        show-ahead head of rx FIFO; rx_ready_i pops it
//   tx_credits_o             current tx credit count
//   overflow_o, misroute_o, credit_err_o   sticky error flags
module noc_local_ni #(
    parameter int XCOORD  = 0,
    parameter int YCOORD  = 0,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_valid_i,
    input  logic [7:0]    tx_dest_i,
    input  logic [7:0]    tx_payload_i,
    output logic          tx_ready_o,
    output logic [15:0]   net_data_o,
    output logic          net_enable_o,
    input  logic          net_credit_i,
    input  logic [15:0]   net_data_i,
    input  logic          net_enable_i,
    output logic          net_credit_o,
    output logic [15:0]   rx_data_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic [CW-1:0] tx_credits_o,
    output logic          overflow_o,
    output logic          misroute_o,
    output logic          credit_err_o
);

    // A depth-1 FIFO still needs a 1-bit pointer; it simply never moves.
    localparam int            PW       = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(CREDITS - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] MAX_CRED = CW'(CREDITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    MY_ADDR  = {XCOORD[3:0], YCOORD[3:0]};

    logic [CW-1:0] credits;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   mem [CREDITS];

    logic send;
    logic pop;
    logic full;
    logic wr_acc;

    assign tx_ready_o   = (credits != '0);
    assign tx_credits_o = credits;
    assign send         = tx_valid_i & tx_ready_o;

    assign rx_valid_o   = (count != '0);
    assign full         = (count == MAX_CRED);
    assign pop          = rx_valid_o & rx_ready_i;
    // A full FIFO can still take a write when the head leaves on the same edge.
    assign wr_acc       = net_enable_i & (~full | pop);
    // Gate the head with valid so an empty FIFO always presents zero.
    assign rx_data_o    = rx_valid_o ? mem[rd_ptr] : 16'h0000;

    // Tx path and credit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits      <= MAX_CRED;
            net_data_o   <= 16'h0000;
            net_enable_o <= 1'b0;
            credit_err_o <= 1'b0;
        end else begin
            net_enable_o <= send;
            if (send) begin
                net_data_o <= {tx_payload_i, tx_dest_i};
            end
            case ({send, net_credit_i})
                2'b10: credits <= credits - CNT_ONE;
                2'b01: begin
                    if (credits == MAX_CRED) begin
                        credit_err_o <= 1'b1;
                    end else begin
                        credits <= credits + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Rx FIFO control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            net_credit_o <= 1'b0;
            overflow_o   <= 1'b0;
            misroute_o   <= 1'b0;
        end else begin
            net_credit_o <= pop;
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
            end
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
                if (net_data_i[7:0] != MY_ADDR) begin
                    misroute_o <= 1'b1;
                end
            end
            if (net_enable_i & ~wr_acc) begin
                overflow_o <= 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: reads are masked by rx_valid_o.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= net_data_i;
        end
    end

endmodule

// File: tb/tb_noc_local_ni.sv
module tb_noc_local_ni;

    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_valid_i = 1'b0;
    logic [7:0]    tx_dest_i = 8'h00;
    logic [7:0]    tx_payload_i = 8'h00;
    logic          tx_ready_o;
    logic [15:0]   net_data_o;
    logic          net_enable_o;
    logic          net_credit_i = 1'b0;
    logic [15:0]   net_data_i = 16'h0000;
    logic          net_enable_i = 1'b0;
    logic          net_credit_o;
    logic [15:0]   rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b0;
    logic [CW-1:0] tx_credits_o;
    logic          overflow_o;
    logic          misroute_o;
    logic          credit_err_o;

    noc_local_ni #(.XCOORD(0), .YCOORD(0), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst),
        .tx_valid_i(tx_valid_i), .tx_dest_i(tx_dest_i), .tx_payload_i(tx_payload_i),
        .tx_ready_o(tx_ready_o),
        .net_data_o(net_data_o), .net_enable_o(net_enable_o), .net_credit_i(net_credit_i),
        .net_data_i(net_data_i), .net_enable_i(net_enable_i), .net_credit_o(net_credit_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_credits_o(tx_credits_o),
        .overflow_o(overflow_o), .misroute_o(misroute_o), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_credits;
    bit          m_net_en;
    logic [15:0] m_net_data;
    bit          m_net_credit;
    logic [15:0] m_q[$];
    bit          m_ovf, m_mis, m_cerr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_credits = CREDITS; m_net_en = 0; m_net_data = 16'h0; m_net_credit = 0;
            m_q.delete(); m_ovf = 0; m_mis = 0; m_cerr = 0;
        end else begin
            bit snd, pp;
            snd = tx_valid_i && (m_credits > 0);
            pp  = rx_ready_i && (m_q.size() > 0);
            m_net_en     = snd;
            m_net_credit = pp;
            if (snd) m_net_data = {tx_payload_i, tx_dest_i};
            if (snd && !net_credit_i) m_credits = m_credits - 1;
            else if (!snd && net_credit_i) begin
                if (m_credits == CREDITS) m_cerr = 1;
                else m_credits = m_credits + 1;
            end
            if (pp) void'(m_q.pop_front());
            if (net_enable_i) begin
                if (m_q.size() < CREDITS) begin
                    m_q.push_back(net_data_i);
                    if (net_data_i[7:0] != 8'h00) m_mis = 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("tx_credits", 32'(tx_credits_o), 32'(m_credits));
        chk("tx_ready", 32'(tx_ready_o), 32'(m_credits != 0));
        chk("net_enable", 32'(net_enable_o), 32'(m_net_en));
        chk("net_data", 32'(net_data_o), 32'(m_net_data));
        chk("net_credit", 32'(net_credit_o), 32'(m_net_credit));
        chk("rx_valid", 32'(rx_valid_o), 32'(m_q.size() != 0));
        chk("rx_data", 32'(rx_data_o), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("misroute", 32'(misroute_o), 32'(m_mis));
        chk("credit_err", 32'(credit_err_o), 32'(m_cerr));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        tx_valid_i = 0; net_credit_i = 0; net_enable_i = 0; rx_ready_i = 0;
    endtask

    int credit_pulses;

    initial begin
        logic [15:0] rx_words [5];
        rx_words[0] = 16'h1100; rx_words[1] = 16'h2200; rx_words[2] = 16'h3300;
        rx_words[3] = 16'h4400; rx_words[4] = 16'h5500;

        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        // Reset state, literal
        chk("lit_rst_credits", 32'(tx_credits_o), 32'd4);
        chk("lit_rst_ready", 32'(tx_ready_o), 32'd1);
        chk("lit_rst_rxvalid", 32'(rx_valid_o), 32'd0);
        chk("lit_rst_flags", {29'd0, overflow_o, misroute_o, credit_err_o}, 32'd0);

        // Credit exhaustion: five requests, four go out
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1; tx_dest_i = 8'h12; tx_payload_i = 8'hA0 + 8'(i);
            cyc();
            if (i < 4) begin
                chk("lit_exh_en", 32'(net_enable_o), 32'd1);
                chk("lit_exh_data", 32'(net_data_o), {16'h0, 8'hA0 + 8'(i), 8'h12});
            end else begin
                chk("lit_exh_en_blocked", 32'(net_enable_o), 32'd0);
            end
        end
        chk("lit_exh_ready", 32'(tx_ready_o), 32'd0);
        chk("lit_exh_credits", 32'(tx_credits_o), 32'd0);

        // Credit recovery: one credit lets the held 5th flit out
        net_credit_i = 1;
        cyc();
        net_credit_i = 0;
        chk("lit_rec_credits", 32'(tx_credits_o), 32'd1);
        cyc();
        tx_valid_i = 0;
        chk("lit_rec_en", 32'(net_enable_o), 32'd1);
        chk("lit_rec_data", 32'(net_data_o), 32'h0000A412);

        // Simultaneous send and credit at credits=2
        net_credit_i = 1; repeat (2) cyc();
        tx_valid_i = 1; tx_payload_i = 8'h77;
        cyc();
        idle();
        chk("lit_both_credits", 32'(tx_credits_o), 32'd2);
        net_credit_i = 1; repeat (2) cyc();
        net_credit_i = 0;
        cyc();

        // Rx ordering and overflow
        for (int i = 0; i < 5; i++) begin
            net_enable_i = 1; net_data_i = rx_words[i];
            cyc();
        end
        net_enable_i = 0;
        chk("lit_ovf", 32'(overflow_o), 32'd1);
        chk("lit_ovf_valid", 32'(rx_valid_o), 32'd1);
        credit_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            chk("lit_pop_data", 32'(rx_data_o), 32'(rx_words[i]));
            rx_ready_i = 1;
            cyc();
            credit_pulses += int'(net_credit_o);
        end
        rx_ready_i = 0;
        cyc();
        chk("lit_pop_credits", 32'(credit_pulses), 32'd4);
        chk("lit_pop_empty", 32'(rx_valid_o), 32'd0);

        // Misroute and credit error
        net_enable_i = 1; net_data_i = 16'hBE35;
        cyc();
        net_enable_i = 0;
        chk("lit_mis", 32'(misroute_o), 32'd1);
        chk("lit_mis_data", 32'(rx_data_o), 32'h0000BE35);
        net_credit_i = 1;
        cyc();
        net_credit_i = 0;
        chk("lit_cerr", 32'(credit_err_o), 32'd1);
        chk("lit_cerr_credits", 32'(tx_credits_o), 32'd4);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tx_valid_i   = ($urandom_range(0, 99) < 60);
            tx_dest_i    = 8'($urandom);
            tx_payload_i = 8'($urandom);
            net_credit_i = ($urandom_range(0, 99) < 45);
            net_enable_i = ($urandom_range(0, 99) < 50);
            net_data_i   = {8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00};
            rx_ready_i   = ($urandom_range(0, 99) < 50);
            if (c == 1500) begin
                // Mid-stream asynchronous reset
                #2 rst = 1'b0;
                #1;
                chk("lit_arst_credits", 32'(tx_credits_o), 32'd4);
                chk("lit_arst_en", 32'(net_enable_o), 32'd0);
                chk("lit_arst_data", 32'(net_data_o), 32'd0);
                chk("lit_arst_ncred", 32'(net_credit_o), 32'd0);
                chk("lit_arst_rx", {15'd0, rx_valid_o, rx_data_o}, 32'd0);
                chk("lit_arst_flags", {29'd0, overflow_o, misroute_o, credit_err_o}, 32'd0);
                cyc();
                rst = 1'b1;
            end
            cyc();
        end
        idle();
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Local network interface: the endpoint on the far side of a router's L port.
- Tx path: packs core requests into 16-bit flits and drives them into the router's local input FIFO, gated by credits.
- Rx path: accepts flits the router ejects, buffers them for the core, and returns one credit per flit consumed.
- One instance per mesh tile, between the tile core and its router.

Parameters:
- XCOORD, 0, this tile's X coordinate; only bits [3:0] are used.
- YCOORD, 0, this tile's Y coordinate; only bits [3:0] are used.
- CREDITS, 4, depth of the router's local input FIFO. Also the depth of the NI rx FIFO. Must be ≥1.
- CW, $clog2(CREDITS+1), width of the credit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_valid_i  in  1  core has a flit to send.
- tx_dest_i  in  8  destination: [7:4]=X, [3:0]=Y.
- tx_payload_i  in  8  payload byte.
- tx_ready_o  out  1  NI can accept a tx flit this cycle.
- net_data_o  out  16  flit to router: {payload, dest}.
- net_enable_o  out  1  one-cycle write strobe to the router's input FIFO.
- net_credit_i  in  1  router freed one slot in its local input FIFO.
- net_data_i  in  16  flit from the router.
- net_enable_i  in  1  router write strobe for net_data_i.
- net_credit_o  out  1  one-cycle pulse: NI freed one rx slot.
- rx_data_o  out  16  head-of-FIFO flit (show-ahead).
- rx_valid_o  out  1  rx FIFO not empty.
- rx_ready_i  in  1  core pops the head flit.
- tx_credits_o  out  CW  current tx credit count.
- overflow_o  out  1  sticky: a flit arrived while the rx FIFO was full.
- misroute_o  out  1  sticky: an accepted rx flit had a dest field other than {XCOORD[3:0], YCOORD[3:0]}.
- credit_err_o  out  1  sticky: net_credit_i arrived while the counter was already at CREDITS.

Behaviour:

Reset (rst=0, asynchronous):
- credits=CREDITS.
- net_data_o=0, net_enable_o=0, net_credit_o=0.
- rx FIFO empty: rx_valid_o=0, rx_data_o=0.
- All sticky flags cleared.
- A reset mid-transfer discards all buffered flits and any pending strobes.

Tx path:
- tx_ready_o = (credits != 0). Combinational from the counter register only.
- Send: tx_valid_i & tx_ready_o at a clock edge.
  - net_data_o <= {tx_payload_i, tx_dest_i}.
  - net_enable_o <= 1 for exactly one cycle. Latency: 1 cycle from the accepting edge.
- Back-to-back sends are allowed (net_enable_o high on consecutive cycles) while credits remain.
- net_data_o holds its last value when idle.

Credit counter update:
- Send only: -1.
- net_credit_i only: +1.
- Both in the same cycle: unchanged.
- net_credit_i at CREDITS with no send: saturate at CREDITS and set credit_err_o.
- Underflow is impossible, because a send requires credits > 0.

Self-addressed tx flits are legal; the NI does not check them.

Rx path (circular FIFO, CREDITS entries, read/write pointers plus an occupancy count):
- Write: net_enable_i at an edge stores net_data_i.
  - If full and no pop in that cycle: drop the flit, set overflow_o, occupancy unchanged.
  - If full and popping in that cycle: accept the write; occupancy stays full.
- Pop: rx_valid_o & rx_ready_i. Advances the read pointer and sets net_credit_o=1 for one cycle, registered on the same edge.
- Simultaneous write and pop: occupancy unchanged, both pointers advance.
- rx_ready_i while empty: ignored, no credit.
- Write to an empty FIFO: rx_valid_o=1 and rx_data_o valid on the next cycle (1-cycle latency).
- Pointers wrap modulo CREDITS; non-power-of-two depths must work.
- misroute_o is set on accepted writes only, checking net_data_i[7:0]. The flit is still delivered.

Sticky flags clear only on reset.

Test Plan:
- Reset, then idle.
  → tx_credits_o=4, tx_ready_o=1, rx_valid_o=0, all flags 0.
- Credit exhaustion: 5 consecutive tx_valid_i with dest=0x12, payloads 0xA0..0xA4, no credits returned.
  → 4 net_enable_o pulses carrying 0xA012..0xA312; tx_ready_o=0 after the 4th; tx_credits_o=0.
- Credit recovery: pulse net_credit_i once.
  → tx_credits_o=1; the 5th flit 0xA412 goes out the cycle after the next edge.
- Simultaneous send and credit: send with net_credit_i=1 in the same cycle at credits=2.
  → tx_credits_o stays 2.
- Rx order, credits and overflow: XCOORD=YCOORD=0; write 0x1100, 0x2200, 0x3300, 0x4400, 0x5500 with rx_ready_i=0.
  → first four are buffered, 5th is dropped, overflow_o=1.
  - Then pop all four.
    → rx_data_o in order 0x1100..0x4400; four net_credit_o pulses; rx_valid_o=0 afterwards.
- Misroute and credit_err:
  - Write 0xBE35. → misroute_o=1; the flit is still readable.
  - Pulse net_credit_i at credits=4. → credit_err_o=1, tx_credits_o stays 4.
  - Assert rst mid-stream. → all outputs return to their reset values on the same edge.
